// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, NOP encoding, fetch FSM states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

  // IDLE: nothing outstanding; WAIT: request outstanding;
  // SQUASH: request outstanding but its data belongs to a dead path.
  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_WAIT   = 2'd1,
    FS_SQUASH = 2'd2
  } fetch_state_t;

  // Sequential fetch address; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry output buffer holding a {PC+4, instruction} pair for IF/ID.
// Latency: a load is visible on the outputs the cycle after the load edge.
// Backpressure: holds while not consumed; clear has priority over load.
module fetch_buf
  import cpu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_consume,
  input  logic [INST_W-1:0] i_inst,
  input  logic [ADDR_W-1:0] i_pc4,
  output logic              o_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_pc4
);

  logic              r_valid;
  logic [INST_W-1:0] r_inst;
  logic [ADDR_W-1:0] r_pc4;

  // Occupancy: clear wins, a load refills even when consumed at the same edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  // Payload: only written by a load that is not being cleared.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_inst <= NOP;
      r_pc4  <= '0;
    end else if (i_load && !i_clear) begin
      r_inst <= i_inst;
      r_pc4  <= i_pc4;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, req/ack handshake to imem, one-entry IF/ID buffer.
// Latency: ack edge -> IFID_o the following cycle; one inst/cycle on zero-wait memory.
// Backpressure: Stall_i holds the buffer and blocks new requests; outstanding ones finish.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              Clock_i,
  input  logic              Reset_i,
  input  logic              Stall_i,
  input  logic              Redirect_i,
  input  logic [ADDR_W-1:0] Target_i,
  output logic              IMemReq_o,
  output logic [ADDR_W-1:0] IMemAddr_o,
  input  logic              IMemAck_i,
  input  logic [INST_W-1:0] IMemData_i,
  output logic [ADDR_W-1:0] PC4_o,
  output logic [INST_W-1:0] Inst_o,
  output logic              IFID_o,
  output logic              Flush_o
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_addr;

  logic              w_pending;
  logic              w_squash;
  logic              w_valid;
  logic              w_ifid;
  logic              w_req;
  logic              w_capture;
  logic              w_issue;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_pc4;

  assign w_pending = (r_state != FS_IDLE);
  assign w_squash  = (r_state == FS_SQUASH);

  // A fresh request only starts when the buffer will have room at this edge,
  // so an ack can never land on top of an unconsumed instruction.
  assign w_ifid    = w_valid & ~Stall_i;
  assign w_req     = ~Reset_i & (w_pending | (~Redirect_i & (~w_valid | w_ifid)));
  assign w_addr    = w_pending ? r_req_addr : r_fetch_pc;
  assign w_pc4     = next_pc(w_addr);

  // Data is kept only for a live-path ack not overtaken by a redirect.
  assign w_capture = w_req & IMemAck_i & ~Redirect_i & ~w_squash;
  assign w_issue   = (r_state == FS_IDLE) & w_req;

  // Next-state: a redirect during an outstanding, unacked request poisons it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FS_IDLE: begin
        if (w_req && !IMemAck_i) w_state_nxt = FS_WAIT;
      end
      FS_WAIT: begin
        if (IMemAck_i)       w_state_nxt = FS_IDLE;
        else if (Redirect_i) w_state_nxt = FS_SQUASH;
      end
      FS_SQUASH: begin
        if (IMemAck_i) w_state_nxt = FS_IDLE;
      end
      default: w_state_nxt = FS_IDLE;
    endcase
  end

  // State register; reset forgets any outstanding memory transaction.
  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) r_state <= FS_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Latch the request address at issue so it stays stable until the ack.
  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i)      r_req_addr <= '0;
    else if (w_issue) r_req_addr <= w_addr;
  end

  // Fetch pointer: redirect target wins, otherwise advance past each capture.
  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i)         r_fetch_pc <= RESET_PC;
    else if (Redirect_i) r_fetch_pc <= Target_i;
    else if (w_capture)  r_fetch_pc <= w_pc4;
  end

  fetch_buf u_buf (
    .i_clk     (Clock_i),
    .i_rst     (Reset_i),
    .i_clear   (Redirect_i),
    .i_load    (w_capture),
    .i_consume (w_ifid),
    .i_inst    (IMemData_i),
    .i_pc4     (w_pc4),
    .o_valid   (w_valid),
    .o_inst    (Inst_o),
    .o_pc4     (PC4_o)
  );

  assign IMemReq_o  = w_req;
  assign IMemAddr_o = w_addr;
  assign IFID_o     = w_ifid;
  assign Flush_o    = Redirect_i & ~Reset_i;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with a transaction-level memory and pipeline model.
// Each cycle: drive stall/redirect at negedge, answer the request, compare outputs.
// Directed segments: zero-wait streaming, fixed latency, reset while squashing.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redir;
  logic [31:0] target;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  logic [31:0] pc4;
  logic [31:0] inst;
  logic        ifid;
  logic        flush;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clock_i    (clk),
    .Reset_i    (rst),
    .Stall_i    (stall),
    .Redirect_i (redir),
    .Target_i   (target),
    .IMemReq_o  (req),
    .IMemAddr_o (addr),
    .IMemAck_i  (ack),
    .IMemData_i (data),
    .PC4_o      (pc4),
    .Inst_o     (inst),
    .IFID_o     (ifid),
    .Flush_o    (flush)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];        // instructions waiting to be handed to ID
  logic [31:0] mdl_fetch;   // next program-order address to fetch
  logic [31:0] m_addr;      // address of the outstanding memory transaction
  bit          m_out;       // memory transaction outstanding
  bit          m_wrong;     // outstanding transaction is on a dead path
  int          m_lat;
  int          m_cnt;
  int          lat_min, lat_max, p_stall, p_redir;
  bit          force_redir;

  task automatic mdl_reset();
    q.delete();
    mdl_fetch = 32'h0000_0000;
    m_addr    = 32'h0;
    m_out     = 1'b0;
    m_wrong   = 1'b0;
    m_cnt     = 0;
    m_lat     = 0;
  endtask

  task automatic step();
    bit          s, r, exp_req, a, popped;
    logic [31:0] t, a_addr;
    @(negedge clk);
    s = ($urandom_range(99) < p_stall);
    r = force_redir || ($urandom_range(99) < p_redir);
    t = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
    stall  = s;
    redir  = r;
    target = t;
    ack    = 1'b0;
    data   = $urandom;
    #1;
    // Memory side: a request is expected whenever something is outstanding, or
    // when there is no redirect and the buffer is empty or being taken by ID.
    exp_req = m_out || (!r && (q.size() == 0 || !s));
    chk("imem_req", {31'b0, req}, {31'b0, exp_req});
    a_addr = m_out ? m_addr : mdl_fetch;
    if (exp_req) chk("imem_addr", addr, a_addr);
    if (exp_req && !m_out) begin
      m_lat = $urandom_range(lat_max, lat_min);
      m_cnt = 0;
    end
    a    = exp_req && (m_cnt == m_lat);
    ack  = a;
    data = a ? memfn(a_addr) : $urandom;
    #1;
    chk("ifid", {31'b0, ifid}, {31'b0, (q.size() != 0 && !s)});
    chk("flush", {31'b0, flush}, {31'b0, r});
    if (q.size() != 0) begin
      chk("pc4", pc4, q[0].pc4);
      chk("inst", inst, q[0].inst);
    end
    // Advance the model to the state after the coming rising edge.
    popped = (q.size() != 0) && !s;
    if (r) q.delete();
    else if (popped) void'(q.pop_front());
    if (a && !m_wrong && !r) begin
      q.push_back('{a_addr + 32'd4, memfn(a_addr)});
      mdl_fetch = a_addr + 32'd4;
    end
    if (r) mdl_fetch = t;
    if (a) begin
      m_out   = 1'b0;
      m_wrong = 1'b0;
    end else if (exp_req) begin
      if (r && m_out) m_wrong = 1'b1;
      if (!m_out) m_addr = a_addr;
      m_out = 1'b1;
      m_cnt++;
    end
  endtask

  task automatic run(input int n, input int lmin, input int lmax, input int ps, input int pr);
    lat_min = lmin; lat_max = lmax; p_stall = ps; p_redir = pr;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'b0, req},   32'h0);
    chk({tag, "_ifid"},  {31'b0, ifid},  32'h0);
    chk({tag, "_flush"}, {31'b0, flush}, 32'h0);
    chk({tag, "_inst"},  inst,           32'h0);
    chk({tag, "_pc4"},   pc4,            32'h0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redir = 1'b1; target = 32'h40;
    ack = 1'b1; data = 32'hDEAD_BEEF; force_redir = 1'b0;
    lat_min = 0; lat_max = 0; p_stall = 0; p_redir = 0;
    mdl_reset();
    #1;
    chk_reset_outputs("rst0");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0; redir = 1'b0; ack = 1'b0;
    mdl_reset();

    run(12, 0, 0, 0, 0);     // zero-wait streaming
    run(15, 2, 2, 0, 0);     // three cycles per request
    run(30, 0, 1, 50, 0);    // stalls
    run(400, 0, 3, 30, 10);  // everything mixed

    // Get a request outstanding on slow memory, then redirect to poison it.
    lat_min = 3; lat_max = 3; p_stall = 0; p_redir = 0;
    for (int i = 0; i < 10 && !m_out; i++) step();
    force_redir = 1'b1;
    step();
    force_redir = 1'b0;
    // Reset in the middle of the squashed transaction, with a stray ack.
    @(negedge clk);
    rst = 1'b1; redir = 1'b1; stall = 1'b0; ack = 1'b1; data = $urandom;
    #1;
    chk_reset_outputs("rst_sq");
    @(posedge clk);
    #1;
    rst = 1'b0; redir = 1'b0; ack = 1'b0;
    mdl_reset();

    run(10, 0, 0, 0, 0);
    run(150, 0, 3, 25, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: holds the fetch PC and runs a request/acknowledge handshake to a variable-latency instruction memory.
- Delivers {PC+4, instruction} pairs into the IF/ID pipeline register via a one-entry output buffer, and produces that register's write-enable and flush controls.
- Handles hazard stalls and branch/jump redirects, including squashing an in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.

Ports:
- Clock_i  input  1  clock; all state updates on the rising edge.
- Reset_i  input  1  asynchronous, active-high reset.
- Stall_i  input  1  hazard unit: ID stage cannot accept an instruction this cycle.
- Redirect_i  input  1  taken branch/jump resolved this cycle.
- Target_i  input  32  redirect address; valid when Redirect_i=1.
- IMemReq_o  output  1  instruction-memory request.
- IMemAddr_o  output  32  request address; held stable while the request is pending.
- IMemAck_i  input  1  memory acknowledge; IMemData_i is valid in the same cycle.
- IMemData_i  input  32  fetched instruction.
- PC4_o  output  32  buffered PC+4 driven to IF/ID.
- Inst_o  output  32  buffered instruction driven to IF/ID.
- IFID_o  output  1  IF/ID write enable.
- Flush_o  output  1  IF/ID flush.

Behaviour:
- Registers:
  - FetchPC_q: next address to fetch.
  - ReqAddr_q: address of the pending request.
  - Pending_q: a request was issued and is not yet acknowledged.
  - Squash_q: the pending request must be discarded.
  - Valid_q, Inst_q, PC4_q: the one-entry output buffer.
- Reset (asynchronous, any time, including mid-request):
  - FetchPC_q=RESET_PC; ReqAddr_q=0; Pending_q=0; Squash_q=0; Valid_q=0; Inst_q=0; PC4_q=0.
  - Any outstanding memory transaction is forgotten; the instruction memory is reset by the same Reset_i.
  - Outputs during reset: IMemReq_o=0, IFID_o=0, Flush_o=0, Inst_o=0, PC4_o=0.
- FSM, encoded by Pending_q/Squash_q:
  - IDLE: Pending=0.
  - WAIT: Pending=1, Squash=0.
  - SQUASH: Pending=1, Squash=1.
- Combinational outputs:
  - IMemReq_o = Pending_q | (~Redirect_i & (~Valid_q | IFID_o)). A new request starts only when the buffer is empty or is being consumed at this edge, so an ack never lands in a full buffer.
  - IMemAddr_o = Pending_q ? ReqAddr_q : FetchPC_q.
  - IFID_o = Valid_q & ~Stall_i.
  - Flush_o = Redirect_i (same cycle, so IF/ID clears the wrong-path entry).
  - Inst_o = Inst_q; PC4_o = PC4_q.
- Request issued and not acknowledged: Pending_q<=1, ReqAddr_q<=IMemAddr_o (IDLE->WAIT). The request stays high until the ack.
- Ack in WAIT or IDLE (zero-wait ack in the issue cycle allowed) with no redirect:
  - Inst_q<=IMemData_i; PC4_q<=IMemAddr_o+4; Valid_q<=1; FetchPC_q<=IMemAddr_o+4; Pending_q<=0.
  - Adds are modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Consumption: at an edge with IFID_o=1 and no capture, Valid_q<=0. A simultaneous consume and capture keeps Valid_q=1 with the new data.
- Stall: Valid_q, Inst_q and PC4_q hold; no new request starts; a pending request still completes into the buffer.
- Redirect_i=1 (priority over stall and ack):
  - FetchPC_q<=Target_i; Valid_q<=0; no new request starts this cycle.
  - If Pending_q=1 and IMemAck_i=0: Squash_q<=1 (WAIT->SQUASH).
  - If the ack arrives in the redirect cycle: the data is discarded and Pending_q<=0.
- SQUASH: the request stays high with the old ReqAddr_q. On ack, the data is discarded, Pending_q<=0, Squash_q<=0 (->IDLE), and the next cycle requests FetchPC_q. A further redirect in SQUASH only updates FetchPC_q.
- Throughput: with zero-wait memory and no stalls, one instruction per cycle. Latency is ack edge -> IFID_o high in the next cycle.

Decomposition:
- Shared package (cpu_pkg):
  - INST_W=32, ADDR_W=32.
  - NOP encoding 32'h0.
  - Fetch state enum {FS_IDLE, FS_WAIT, FS_SQUASH}.
- Optional sub-module fetch_buf: the one-entry valid/data buffer with load/consume/clear. Everything else stays flat.

Test Plan:
- Reset release, zero-wait memory (ack in the request cycle), no stall -> addresses 0,4,8 in consecutive cycles; IFID_o high from cycle 2; PC4_o 4,8,12 in successive cycles.
- Memory with 3-cycle ack latency -> IMemAddr_o stable at 0x0 for 3 cycles; one instruction delivered per 3 cycles; IFID_o pulses one cycle each.
- Stall_i high for 4 cycles with Valid_q=1 -> Inst_o/PC4_o frozen, IFID_o=0, IMemReq_o=0; the instruction is delivered on the first cycle Stall_i drops.
- Redirect_i with Target_i=0x100 while a request to 0x8 is pending (ack 2 cycles later) -> Flush_o=1 that cycle; the ack data for 0x8 is discarded; the next request goes to 0x100; PC4_o=0x104 is delivered.
- Redirect_i in the same cycle as an ack for 0x10 (Target_i=0x40) -> the 0x10 data is never presented; the next fetch is 0x40.
- Reset_i asserted while in SQUASH -> all outputs drop immediately (asynchronous); after release the fetch restarts at RESET_PC; the stale ack is not captured.
